// File: rtl/gray_code_converter_pipe.sv
// gray_code_converter_pipe: two-stage binary<->Gray converter, valid/ready both sides.
// Define GRAY_ADJ_CHECK_EN to add the sticky adj_err flag for non-adjacent Gray inputs.
module gray_code_converter_pipe #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_mode,
  output logic [CNT_WIDTH-1:0] conv_count
`ifdef GRAY_ADJ_CHECK_EN
  ,
  output logic                 adj_err
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic             s1_mode;
  logic [WIDTH-1:0] conv;
  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  function automatic logic [WIDTH-1:0] bin2gray(
    input logic [WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; this is the long path between S1 and S2.
  function automatic logic [WIDTH-1:0] gray2bin(
    input logic [WIDTH-1:0] g
  );
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = s1_valid & s2_adv;
  assign in_ready = rst_n & (!s1_valid | s2_adv);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign conv     = s1_mode ? gray2bin(s1_data)
                            : bin2gray(s1_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_fire) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_mode   <= 1'b0;
      conv_count <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= s1_valid;
      end
      if (s1_adv) begin
        out_data <= conv;
        out_mode <= s1_mode;
      end
      if (out_fire) begin
        conv_count <= conv_count + CNT_WIDTH'(1);
      end
    end
  end

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_gray;
  logic [WIDTH-1:0] diff;
  logic             have_prev;
  logic             one_hot;

  assign diff    = prev_gray ^ in_data;
  assign one_hot = (diff != '0) &&
                   ((diff & (diff - WIDTH'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
      adj_err   <= 1'b0;
    end else if (in_fire && in_mode) begin
      prev_gray <= in_data;
      have_prev <= 1'b1;
      if (have_prev && !one_hot) begin
        adj_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_code_converter_pipe.sv
// tb_gray_code_converter_pipe: directed and random checks of the converter pipe.
// Instance a is 4 bits wide, instance b is 8 bits wide with a 2-bit counter.
module tb_gray_code_converter_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_mode;
  logic [3:0]  a_in_data, a_out_data;
  logic        a_out_valid, a_out_ready, a_out_mode;
  logic [15:0] a_conv_count;
  logic        a_adj_err;

  logic        b_in_valid, b_in_ready, b_in_mode;
  logic [7:0]  b_in_data, b_out_data;
  logic        b_out_valid, b_out_ready, b_out_mode;
  logic [1:0]  b_conv_count;
  logic        b_adj_err;

  int compared = 0;
  int mismatched = 0;

  gray_code_converter_pipe #(.WIDTH(4), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_mode(a_out_mode),
    .conv_count(a_conv_count)
`ifdef GRAY_ADJ_CHECK_EN
    , .adj_err(a_adj_err)
`endif
  );

  gray_code_converter_pipe #(.WIDTH(8), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_mode(b_out_mode),
    .conv_count(b_conv_count)
`ifdef GRAY_ADJ_CHECK_EN
    , .adj_err(b_adj_err)
`endif
  );

`ifndef GRAY_ADJ_CHECK_EN
  assign a_adj_err = 1'b0;
  assign b_adj_err = 1'b0;
`endif

  // Gray->binary as the XOR of all right shifts of the code word.
  function automatic logic [7:0] ref_conv(
    input logic [7:0] d, input logic m, input int w
  );
    logic [7:0] r;
    if (!m) return d ^ (d >> 1);
    r = '0;
    for (int k = 0; k < w; k++) r ^= d >> k;
    return r;
  endfunction

  task automatic idle_inputs();
    a_in_valid = 0; a_in_data = '0; a_in_mode = 0;
    a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = 0;
    b_out_ready = 1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    compared++;
    if (a_out_valid !== 1'b0 || a_out_data !== 4'h0 ||
        a_out_mode !== 1'b0 || a_conv_count !== 16'h0) begin
      mismatched++;
      $display("FAIL reset_a: v=%b d=%h m=%b c=%0d want 0",
               a_out_valid, a_out_data, a_out_mode, a_conv_count);
    end
    compared++;
    if (b_out_valid !== 1'b0 || b_out_data !== 8'h0 ||
        b_conv_count !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_b: v=%b d=%h c=%0d want 0",
               b_out_valid, b_out_data, b_conv_count);
    end
    @(negedge clk);
    rst_n = 1;
    next_cycle();
    @(negedge clk);
    compared++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_ready: a=%b b=%b want 1",
               a_in_ready, b_in_ready);
    end
    next_cycle();
  endtask

  task automatic test_single();
    apply_reset();
    a_in_valid = 1; a_in_data = 4'b0011; a_in_mode = 0;
    @(negedge clk);
    compared++;
    if (a_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL single_ready: got %b want 1", a_in_ready);
    end
    next_cycle();
    a_in_valid = 0;
    @(negedge clk);
    compared++;
    if (a_out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_early: out_valid %b want 0", a_out_valid);
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (a_out_valid !== 1'b1 || a_out_data !== 4'b0010 ||
        a_out_mode !== 1'b0) begin
      mismatched++;
      $display("FAIL single_out: v=%b d=%b m=%b want 1 0010 0",
               a_out_valid, a_out_data, a_out_mode);
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (a_out_valid !== 1'b0 || a_conv_count !== 16'd1) begin
      mismatched++;
      $display("FAIL single_after: v=%b c=%0d want 0 1",
               a_out_valid, a_conv_count);
    end
    next_cycle();
  endtask

  task automatic test_gray_stream();
    logic [3:0] exp_d [2];
    exp_d[0] = 4'b0100;
    exp_d[1] = 4'b0101;
    apply_reset();
    a_in_valid = 1; a_in_mode = 1; a_in_data = 4'b0110;
    next_cycle();
    a_in_data = 4'b0111;
    next_cycle();
    a_in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c < 2) begin
        compared++;
        if (a_out_valid !== 1'b1 || a_out_data !== exp_d[c] ||
            a_out_mode !== 1'b1) begin
          mismatched++;
          $display("FAIL gray_stream[%0d]: v=%b d=%b m=%b want 1 %b 1",
                   c, a_out_valid, a_out_data, a_out_mode, exp_d[c]);
        end
      end else begin
        compared++;
        if (a_out_valid !== 1'b0 || a_conv_count !== 16'd2) begin
          mismatched++;
          $display("FAIL gray_stream_end: v=%b c=%0d want 0 2",
                   a_out_valid, a_conv_count);
        end
      end
`ifdef GRAY_ADJ_CHECK_EN
      compared++;
      if (a_adj_err !== 1'b0) begin
        mismatched++;
        $display("FAIL gray_stream_adj: got %b want 0", a_adj_err);
      end
`endif
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] got [$];
    logic [3:0] exp_d [3];
    exp_d[0] = 4'b0001; exp_d[1] = 4'b0011; exp_d[2] = 4'b0010;
    apply_reset();
    a_out_ready = 0;
    a_in_valid = 1; a_in_mode = 0;
    for (int c = 0; c < 4; c++) begin
      a_in_data = (c < 2) ? 4'(c + 1) : 4'b0011;
      @(negedge clk);
      compared++;
      if (a_in_ready !== (c < 2)) begin
        mismatched++;
        $display("FAIL bp_ready[%0d]: got %b want %b",
                 c, a_in_ready, c < 2);
      end
      if (c >= 2) begin
        compared++;
        if (a_out_valid !== 1'b1 || a_out_data !== 4'b0001) begin
          mismatched++;
          $display("FAIL bp_hold[%0d]: v=%b d=%b want 1 0001",
                   c, a_out_valid, a_out_data);
        end
      end
      next_cycle();
    end
    a_out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_out_valid && a_out_ready) got.push_back(a_out_data);
      if (a_in_valid && a_in_ready) begin
        next_cycle();
        a_in_valid = 0;
      end else begin
        next_cycle();
      end
    end
    compared++;
    if (got.size() != 3) begin
      mismatched++;
      $display("FAIL bp_count: got %0d words want 3", got.size());
    end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      compared++;
      if (got[i] !== exp_d[i]) begin
        mismatched++;
        $display("FAIL bp_order[%0d]: got %b want %b",
                 i, got[i], exp_d[i]);
      end
    end
    @(negedge clk);
    compared++;
    if (a_conv_count !== 16'd3) begin
      mismatched++;
      $display("FAIL bp_conv_count: got %0d want 3", a_conv_count);
    end
    next_cycle();
  endtask

  task automatic test_width8_wrap();
    logic [7:0] in_d [4];
    logic [7:0] exp_d [4];
    int         transfers;
    in_d[0] = 8'h80; in_d[1] = 8'hC0;
    in_d[2] = 8'h80; in_d[3] = 8'hC0;
    exp_d[0] = 8'hC0; exp_d[1] = 8'h80;
    exp_d[2] = 8'hC0; exp_d[3] = 8'h80;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      b_in_valid = (c < 4);
      b_in_data  = (c < 4) ? in_d[c] : 8'h00;
      b_in_mode  = (c < 4) ? c[0] : 1'b0;
      @(negedge clk);
      transfers = (c < 2) ? 0 : ((c > 6) ? 4 : c - 2);
      compared++;
      if (b_conv_count !== 2'(transfers % 4)) begin
        mismatched++;
        $display("FAIL w8_count[%0d]: got %0d want %0d",
                 c, b_conv_count, transfers % 4);
      end
      compared++;
      if (b_out_valid !== (c >= 2 && c <= 5)) begin
        mismatched++;
        $display("FAIL w8_valid[%0d]: got %b", c, b_out_valid);
      end else if (c >= 2 && c <= 5) begin
        compared++;
        if (b_out_data !== exp_d[c-2] ||
            b_out_mode !== (c - 2) % 2) begin
          mismatched++;
          $display("FAIL w8_data[%0d]: d=%h m=%b want %h %0d",
                   c, b_out_data, b_out_mode,
                   exp_d[c-2], (c - 2) % 2);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    a_in_valid = 1; a_in_data = 4'b0101; a_in_mode = 0;
    next_cycle();
    a_in_valid = 0;
    repeat (2) next_cycle();
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 4'b0001;
    next_cycle();
    a_in_data = 4'b0010;
    next_cycle();
    a_in_valid = 0;
    @(negedge clk);
    compared++;
    if (a_out_valid !== 1'b1 || a_conv_count !== 16'd1) begin
      mismatched++;
      $display("FAIL mid_pre: v=%b c=%0d want 1 1",
               a_out_valid, a_conv_count);
    end
    next_cycle();
    #2;
    rst_n = 0;
    #1;
    compared++;
    if (a_out_valid !== 1'b0 || a_out_data !== 4'h0 ||
        a_conv_count !== 16'd0) begin
      mismatched++;
      $display("FAIL mid_reset: v=%b d=%h c=%0d want 0 0 0",
               a_out_valid, a_out_data, a_conv_count);
    end
    @(negedge clk);
    rst_n = 1;
    a_out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge clk);
      compared++;
      if (a_out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL mid_stale[%0d]: out_valid %b want 0",
                 c, a_out_valid);
      end
    end
    next_cycle();
  endtask

`ifdef GRAY_ADJ_CHECK_EN
  task automatic test_adj();
    apply_reset();
    a_in_valid = 1; a_in_mode = 1; a_in_data = 4'b0000;
    next_cycle();
    a_in_data = 4'b0011;
    @(negedge clk);
    compared++;
    if (a_adj_err !== 1'b0) begin
      mismatched++;
      $display("FAIL adj_first: got %b want 0", a_adj_err);
    end
    next_cycle();
    a_in_mode = 0; a_in_data = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      compared++;
      if (a_adj_err !== 1'b1) begin
        mismatched++;
        $display("FAIL adj_sticky[%0d]: got %b want 1", c, a_adj_err);
      end
      next_cycle();
    end
    apply_reset();
    compared++;
    if (a_adj_err !== 1'b0) begin
      mismatched++;
      $display("FAIL adj_reset: got %b want 0", a_adj_err);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] q_d [$];
    logic       q_m [$];
    logic [3:0] hold_d, exp_d, prev_g;
    logic       hold_m, exp_m, stall, have_prev, adj_exp;
    int         cnt;
    apply_reset();
    cnt = 0; stall = 0; have_prev = 0; adj_exp = 0;
    prev_g = '0; hold_d = '0; hold_m = 0;
    for (int c = 0; c < 400; c++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = 4'($urandom);
      a_in_mode   = 1'($urandom_range(0, 1));
      a_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      compared++;
      if (a_conv_count !== 16'(cnt)) begin
        mismatched++;
        $display("FAIL rnd_count[%0d]: got %0d want %0d",
                 c, a_conv_count, cnt);
      end
      if (q_d.size() == 0) begin
        compared++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL rnd_empty[%0d]: v=%b rdy=%b want 0 1",
                   c, a_out_valid, a_in_ready);
        end
      end
      if (stall) begin
        compared++;
        if (a_out_valid !== 1'b1 || a_out_data !== hold_d ||
            a_out_mode !== hold_m) begin
          mismatched++;
          $display("FAIL rnd_hold[%0d]: v=%b d=%h m=%b want 1 %h %b",
                   c, a_out_valid, a_out_data, a_out_mode,
                   hold_d, hold_m);
        end
      end
`ifdef GRAY_ADJ_CHECK_EN
      compared++;
      if (a_adj_err !== adj_exp) begin
        mismatched++;
        $display("FAIL rnd_adj[%0d]: got %b want %b",
                 c, a_adj_err, adj_exp);
      end
`endif
      if (a_out_valid && a_out_ready) begin
        compared++;
        if (q_d.size() == 0) begin
          mismatched++;
          $display("FAIL rnd_extra[%0d]: got %h want none",
                   c, a_out_data);
        end else begin
          exp_d = q_d.pop_front();
          exp_m = q_m.pop_front();
          if (a_out_data !== exp_d || a_out_mode !== exp_m) begin
            mismatched++;
            $display("FAIL rnd_data[%0d]: got %h/%b want %h/%b",
                     c, a_out_data, a_out_mode, exp_d, exp_m);
          end
        end
        cnt++;
      end
      if (a_in_valid && a_in_ready) begin
        q_d.push_back(4'(ref_conv({4'h0, a_in_data}, a_in_mode, 4)));
        q_m.push_back(a_in_mode);
        if (a_in_mode) begin
          if (have_prev && $countones(prev_g ^ a_in_data) != 1)
            adj_exp = 1;
          prev_g = a_in_data;
          have_prev = 1;
        end
      end
      stall  = a_out_valid && !a_out_ready;
      hold_d = a_out_data;
      hold_m = a_out_mode;
      next_cycle();
    end
    a_in_valid = 0;
    a_out_ready = 1;
    for (int c = 0; c < 10 && q_d.size() > 0; c++) begin
      @(negedge clk);
      if (a_out_valid) begin
        exp_d = q_d.pop_front();
        exp_m = q_m.pop_front();
        compared++;
        if (a_out_data !== exp_d || a_out_mode !== exp_m) begin
          mismatched++;
          $display("FAIL rnd_drain: got %h/%b want %h/%b",
                   a_out_data, a_out_mode, exp_d, exp_m);
        end
      end
      next_cycle();
    end
    compared++;
    if (q_d.size() != 0) begin
      mismatched++;
      $display("FAIL rnd_lost: %0d words never came out want 0",
               q_d.size());
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_gray_stream();
    test_backpressure();
    test_width8_wrap();
    test_reset_mid();
`ifdef GRAY_ADJ_CHECK_EN
    test_adj();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/gray_code_converter_pipe.md
Name: gray_code_converter_pipe

Overview:
Parametrised, pipelined binary/Gray code converter with a valid/ready handshake on both sides.
- Each accepted word carries a mode bit selecting the direction: binary->Gray or Gray->binary.
- Results emerge two cycles later, in order, with full backpressure support.
- Used wherever multi-bit counters or pointers cross between logic that needs Gray encoding and logic that needs binary arithmetic.

Parameters:
WIDTH, 4, data width in bits (>=2)
CNT_WIDTH, 16, width of the completed-transfer counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  word to convert
in_mode  input  1  0 = binary->Gray, 1 = Gray->binary
out_valid  output  1  result present
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  converted word
out_mode  output  1  mode the result was produced with
conv_count  output  CNT_WIDTH  number of completed output transfers

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_mode=0, conv_count=0, all internal stage valids=0.
  - in_ready is combinational. It is 1 while reset is deasserted and the pipeline is empty.
- Stage 1 (S1) registers in_data and in_mode. Stage 2 (S2) registers the converted word, and drives out_data/out_mode/out_valid directly from registers.
- Arithmetic:
  - Binary->Gray: g[i] = b[i] ^ b[i+1] for i < WIDTH-1; g[WIDTH-1] = b[WIDTH-1].
  - Gray->binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is a full prefix XOR computed between S1 and S2.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_data/out_mode hold stable while out_valid=1 and out_ready=0.
- Flow control:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = s1_valid & s2_adv.
  - in_ready = !s1_valid | s2_adv.
- Latency and throughput:
  - Latency is exactly 2 cycles from input transfer to out_valid with no stall.
  - Throughput is 1 word/cycle while out_ready=1.
- Back-to-back words may mix modes. Each result uses its own mode bit, and order is preserved.
- Full (both stages valid, out_ready=0): in_ready=0, no data lost or overwritten.
- Simultaneous output transfer and input transfer in the same cycle is legal. The pipeline advances one slot.
- conv_count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-operation: all in-flight words are discarded. No out_valid may be asserted in the cycle after rst_n rises unless new input has been accepted two cycles earlier.
- No state machine beyond the stage-valid bits. Each stage is either empty or full.

Optional Feature:
Macro GRAY_ADJ_CHECK_EN.
- When defined:
  - Adds output port adj_err (1 bit, reset 0).
  - For every accepted Gray->binary input after the first one since reset, the block compares it with the previous accepted Gray->binary input. If popcount(prev ^ cur) != 1, adj_err is set one cycle after the transfer.
  - adj_err is sticky until reset.
  - Binary->Gray inputs neither update nor check the stored previous value.
- When undefined: no adj_err port, no comparison logic; datapath and timing are identical.

Test Plan:
1. WIDTH=4, in_mode=0, in_data=4'b0011, out_ready=1 -> out_valid=1 exactly 2 cycles later, out_data=4'b0010, out_mode=0, conv_count=1.
2. WIDTH=4, in_mode=1, stream 4'b0110 then 4'b0111 on consecutive cycles -> out_data 4'b0100 then 4'b0101 on consecutive cycles; with GRAY_ADJ_CHECK_EN, adj_err stays 0.
3. Backpressure: out_ready=0, push 3 words 4'b0001, 4'b0010, 4'b0011 (mode 0) -> in_ready=0 after 2 accepted; out_data holds 4'b0001. Release out_ready -> results 4'b0001, 4'b0011, 4'b0010 in order, none lost.
4. WIDTH=8, mode 0 8'h80 -> 8'hC0; mode 1 8'hC0 -> 8'h80, interleaved back-to-back -> correct per-word mode and out_mode.
5. Reset mid-operation: accept 2 words, assert rst_n=0 asynchronously between edges -> out_valid, out_data and conv_count go to 0 immediately; no stale word appears after release.
6. GRAY_ADJ_CHECK_EN: Gray inputs 4'b0000 then 4'b0011 -> adj_err=1 one cycle after the second transfer, stays 1 until reset; conv_count wrap checked with CNT_WIDTH=2 after 4 transfers -> 0.
